// File: rtl/mux_rr_feeder_pkg.sv
// Shared types for the round-robin mux feeder.
// Requester count, FSM encoding and index type.
package mux_pkg;
  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } feeder_state_t;

  typedef logic [1:0] req_idx_t;
endpackage

// File: rtl/mux_rr_feeder_if.sv
// Requester, mux and output-stage signals of the feeder.
// master = feeder side, slave = environment side.
interface mux_rr_feeder_if #(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 2
);
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  logic [SEL_WIDTH-1:0] mux_sel;
  logic [WIDTH-1:0]     mux_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_src;

  modport master (
    input  req_valid,
    input  mux_out,
    input  out_ready,
    output req_ready,
    output mux_sel,
    output out_valid,
    output out_data,
    output out_src
  );

  modport slave (
    output req_valid,
    output mux_out,
    output out_ready,
    input  req_ready,
    input  mux_sel,
    input  out_valid,
    input  out_data,
    input  out_src
  );
endinterface

// File: rtl/mux_rr_feeder_pick.sv
// Combinational round-robin search: first set
// request at or above ptr, wrapping 3 to 0.
module rr_priority_pick
  import mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic               any,
  output req_idx_t           idx
);

  // Scan farthest offset first so the nearest hit wins.
  always_comb begin
    any = |req;
    idx = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr + req_idx_t'(i)]) begin
        idx = ptr + req_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/mux_rr_feeder.sv
// Round-robin grant FSM driving a 4:1 mux select,
// with a single-entry registered valid/ready output.
module mux_rr_feeder
  import mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 2,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_rr_feeder_if.master bus,
  output logic          grant_active
);

  localparam int BW = $clog2(MAX_BURST + 1);

  feeder_state_t  state, state_n;
  req_idx_t       grant_idx, grant_n;
  req_idx_t       prio_ptr, prio_n;
  logic [BW-1:0]  burst_cnt, burst_n;

  logic           ov_q;
  logic [WIDTH-1:0] od_q;
  req_idx_t       os_q;

  logic           pick_any;
  req_idx_t       pick_idx;
  logic           gvalid;
  logic           xfer;

  rr_priority_pick u_pick (
    .req (bus.req_valid),
    .ptr (prio_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign gvalid = bus.req_valid[grant_idx];
  assign xfer   = (state == GRANT) && gvalid
                  && (!ov_q || bus.out_ready);

  always_comb begin
    state_n = state;
    grant_n = grant_idx;
    prio_n  = prio_ptr;
    burst_n = burst_cnt;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          grant_n = pick_idx;
          burst_n = '0;
        end
      end
      GRANT: begin
        if (!gvalid) begin
          state_n = IDLE;
          prio_n  = grant_idx + 2'd1;
        end else if (xfer) begin
          burst_n = burst_cnt + BW'(1);
          if (burst_cnt == BW'(MAX_BURST - 1)) begin
            state_n = IDLE;
            prio_n  = grant_idx + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      prio_ptr  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_n;
      prio_ptr  <= prio_n;
      burst_cnt <= burst_n;
    end
  end

  // Load and drain in one cycle keep the stage full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      od_q <= '0;
      os_q <= '0;
    end else if (xfer) begin
      ov_q <= 1'b1;
      od_q <= bus.mux_out;
      os_q <= grant_idx;
    end else if (ov_q && bus.out_ready) begin
      ov_q <= 1'b0;
    end
  end

  assign bus.req_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;
  assign bus.mux_sel   = SEL_WIDTH'(grant_idx);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_src   = SEL_WIDTH'(os_q);
  assign grant_active  = (state == GRANT);

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Self-checking bench for mux_rr_feeder: directed
// scenarios plus random traffic against a reference model.
module tb_mux_rr_feeder;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       grant_active;
  logic [7:0] din [4];

  always #5 clk = ~clk;

  mux_rr_feeder_if #(.WIDTH(8), .SEL_WIDTH(2)) bus ();

  assign bus.mux_out = din[bus.mux_sel];

  mux_rr_feeder #(
    .WIDTH(8), .SEL_WIDTH(2), .MAX_BURST(MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.master),
    .grant_active (grant_active)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         m_busy;
  bit         m_ov;
  int         m_g;
  int         m_ptr;
  int         m_n;
  logic [7:0] m_od;
  int         m_os;

  task automatic model_clear();
    m_busy = 0; m_ov = 0; m_g = 0; m_ptr = 0;
    m_n = 0; m_od = 8'h00; m_os = 0;
  endtask

  // One clock of the arbitration rules, using current inputs.
  task automatic model_step();
    logic [3:0] v;
    bit         rdy;
    bit         take;
    v   = bus.req_valid;
    rdy = bus.out_ready;
    if (!m_busy) begin
      if (m_ov && rdy) m_ov = 0;
      if (v != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (v[(m_ptr + k) % 4]) begin
            m_g = (m_ptr + k) % 4;
            break;
          end
        end
        m_busy = 1;
        m_n = 0;
      end
    end else begin
      take = v[m_g] && (!m_ov || rdy);
      if (take) begin
        m_od = din[m_g];
        m_os = m_g;
        m_ov = 1;
        m_n  = m_n + 1;
      end else if (m_ov && rdy) begin
        m_ov = 0;
      end
      if (!v[m_g] || (take && m_n == MB)) begin
        m_busy = 0;
        m_ptr  = (m_g + 1) % 4;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;
    #7;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_src, bus.req_ready,
         grant_active, bus.mux_sel} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outs got ov=%b d=%h s=%0d rr=%b ga=%b sel=%0d req all 0",
               bus.out_valid, bus.out_data, bus.out_src, bus.req_ready,
               grant_active, bus.mux_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (grant_active !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL idle_hold cyc %0d got ga=%b ov=%b rr=%b req 0 0 0000",
                 c, grant_active, bus.out_valid, bus.req_ready);
      end
    end
  endtask

  task automatic test_burst_cap();
    int bc [8];
    int nb = 0;
    int exp_c [8] = '{2, 3, 4, 5, 7, 8, 9, 10};
    apply_reset();
    din[0] = 8'hA5;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 20 && nb < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        checks++;
        if (bus.out_data !== 8'hA5 || bus.out_src !== 2'd0) begin
          errors++;
          $display("FAIL burst_beat got d=%h s=%0d req A5 0",
                   bus.out_data, bus.out_src);
        end
        bc[nb] = c;
        nb++;
      end
    end
    checks++;
    if (nb != 8) begin
      errors++;
      $display("FAIL burst_count got %0d req 8", nb);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (bc[k] != exp_c[k]) begin
          errors++;
          $display("FAIL burst_timing beat %0d got cyc %0d req %0d",
                   k, bc[k], exp_c[k]);
        end
      end
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_fairness();
    int bc [17];
    int nb = 0;
    logic [1:0] es;
    apply_reset();
    din[0] = 8'hA5; din[1] = 8'h3C;
    din[2] = 8'h7E; din[3] = 8'hFF;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 60 && nb < 17; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        es = 2'((nb / 4) % 4);
        checks++;
        if (bus.out_src !== es || bus.out_data !== din[es]) begin
          errors++;
          $display("FAIL rr_order beat %0d got s=%0d d=%h req s=%0d d=%h",
                   nb, bus.out_src, bus.out_data, es, din[es]);
        end
        bc[nb] = c;
        nb++;
      end
    end
    checks++;
    if (nb != 17) begin
      errors++;
      $display("FAIL rr_count got %0d req 17", nb);
    end else begin
      checks++;
      if (bc[16] - bc[0] != 20) begin
        errors++;
        $display("FAIL rr_span got %0d req 20", bc[16] - bc[0]);
      end
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    apply_reset();
    din[1] = 8'h3C;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0010;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C ||
          bus.out_src !== 2'd1 || bus.req_ready !== 4'b0000 ||
          grant_active !== 1'b1) begin
        errors++;
        $display("FAIL stall cyc %0d got ov=%b d=%h s=%0d rr=%b ga=%b req 1 3C 1 0000 1",
                 c, bus.out_valid, bus.out_data, bus.out_src,
                 bus.req_ready, grant_active);
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL resume_ready got %b req 0010", bus.req_ready);
    end
    if (bus.out_valid) cnt++;
    for (int c = 0; c < 10 && grant_active; c++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    checks++;
    if (cnt != MB) begin
      errors++;
      $display("FAIL stall_burst got %0d beats req %0d", cnt, MB);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_drop();
    apply_reset();
    din[0] = 8'h11; din[2] = 8'h7E; din[3] = 8'hFF;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.mux_sel !== 2'd2 || bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL drop_grant got sel=%0d rr=%b req 2 0100",
               bus.mux_sel, bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 4'b1001;
    @(negedge clk);
    checks++;
    if (grant_active !== 1'b1 || bus.req_ready !== 4'b0000 ||
        bus.out_valid !== 1'b1 || bus.out_data !== 8'h7E ||
        bus.out_src !== 2'd2) begin
      errors++;
      $display("FAIL drop_cycle got ga=%b rr=%b ov=%b d=%h s=%0d req 1 0000 1 7E 2",
               grant_active, bus.req_ready, bus.out_valid,
               bus.out_data, bus.out_src);
    end
    @(negedge clk);
    checks++;
    if (grant_active !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle got ga=%b ov=%b req 0 0",
               grant_active, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (grant_active !== 1'b1 || bus.mux_sel !== 2'd3 ||
        bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL drop_next got ga=%b sel=%0d rr=%b req 1 3 1000",
               grant_active, bus.mux_sel, bus.req_ready);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_async_reset();
    apply_reset();
    din[0] = 8'h11; din[1] = 8'h22;
    din[2] = 8'h7E; din[3] = 8'h44;
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0100;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h7E) begin
      errors++;
      $display("FAIL arst_setup got ov=%b d=%h req 1 7E",
               bus.out_valid, bus.out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        grant_active !== 1'b0 || bus.mux_sel !== 2'd0 ||
        bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL arst_now got ov=%b d=%h ga=%b sel=%0d rr=%b req 0 00 0 0 0000",
               bus.out_valid, bus.out_data, grant_active,
               bus.mux_sel, bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (grant_active !== 1'b1 || bus.mux_sel !== 2'd0 ||
        bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL arst_restart got ga=%b sel=%0d rr=%b req 1 0 0001",
               grant_active, bus.mux_sel, bus.req_ready);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] er;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3) == 0)
          bus.req_valid[i] = ~bus.req_valid[i];
        din[i] = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      er = (m_busy && bus.req_valid[m_g] && (!m_ov || bus.out_ready))
           ? (4'b0001 << m_g) : 4'b0000;
      checks++;
      if (bus.out_valid !== m_ov || bus.out_data !== m_od ||
          bus.out_src !== 2'(m_os)) begin
        errors++;
        $display("FAIL rnd_out cyc %0d got ov=%b d=%h s=%0d req %b %h %0d",
                 c, bus.out_valid, bus.out_data, bus.out_src,
                 m_ov, m_od, m_os);
      end
      checks++;
      if (bus.req_ready !== er || grant_active !== m_busy ||
          bus.mux_sel !== 2'(m_g)) begin
        errors++;
        $display("FAIL rnd_ctl cyc %0d got rr=%b ga=%b sel=%0d req %b %b %0d",
                 c, bus.req_ready, grant_active, bus.mux_sel,
                 er, m_busy, m_g);
      end
      model_step();
      @(posedge clk);
      #1;
    end
    bus.req_valid = 4'b0000;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    rst_n = 1'b0;
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_burst_cap();
    test_fairness();
    test_backpressure();
    test_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
